// File: rtl/diff_fm_wb_ctrl.sv
// Write-back controller for one PE column: ReLU + saturating shift requantisation,
// sequential fill of the feature-map buffer port A and ping-pong bank swap.
module diff_fm_wb_ctrl #(
  parameter int ACC_W             = 16,
  parameter int BIT_LENGTH        = 8,
  parameter int CONF_FM_BUF_DEPTH = 16,
  parameter int DEPTH             = CONF_FM_BUF_DEPTH,
  parameter int ADDR_W            = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  layer_start_i,
  input  logic [ADDR_W:0]       layer_len_i,
  input  logic [3:0]            shift_i,
  input  logic [ACC_W-1:0]      wb_data_i,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic                  rd_release_i,
  output logic [ADDR_W-1:0]     addra,
  output logic [BIT_LENGTH-1:0] dina,
  output logic                  wea,
  output logic                  ena,
  output logic                  ping_pong,
  output logic                  layer_done_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {IDLE, FILL, WAIT_SWAP} state_t;

  localparam logic [ADDR_W:0]       DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ACC_W-1:0]      SAT_W   = ACC_W'((1 << (BIT_LENGTH-1)) - 1);
  localparam logic [BIT_LENGTH-1:0] SAT_B   = BIT_LENGTH'((1 << (BIT_LENGTH-1)) - 1);

  state_t                state_q, state_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [3:0]            shift_q, shift_d;
  logic [ADDR_W-1:0]     cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  ena_q, ena_d;
  logic [ADDR_W-1:0]     addra_q, addra_d;
  logic [BIT_LENGTH-1:0] dina_q, dina_d;
  logic                  pp_q, pp_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rd_free_q, rd_free_d;

  logic                  accept;
  logic                  last;
  logic                  len_ok;
  logic [ADDR_W:0]       len_m1;
  logic [ACC_W-1:0]      shifted;
  logic [BIT_LENGTH-1:0] requant;

  assign accept  = wb_valid_i & ready_q;
  assign len_m1  = len_q - 1'b1;
  assign last    = ({1'b0, cnt_q} == len_m1);
  assign len_ok  = (layer_len_i != '0) && (layer_len_i <= DEPTH_L);
  assign shifted = wb_data_i >> shift_q;

  // Negative results clamp to zero; positive ones saturate at the signed max.
  always_comb begin
    requant = '0;
    if (!wb_data_i[ACC_W-1])
      requant = (shifted > SAT_W) ? SAT_B : shifted[BIT_LENGTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    ena_d     = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    pp_d      = pp_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rd_free_d = rd_free_q | rd_release_i;
    case (state_q)
      IDLE: begin
        if (layer_start_i) begin
          if (len_ok) begin
            len_d   = layer_len_i;
            shift_d = shift_i;
            cnt_d   = '0;
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (layer_start_i) err_d = 1'b1;
        if (accept) begin
          ena_d   = 1'b1;
          addra_d = cnt_q;
          dina_d  = requant;
          if (last) state_d = WAIT_SWAP;
          else      cnt_d   = cnt_q + 1'b1;
        end
      end
      WAIT_SWAP: begin
        if (layer_start_i) err_d = 1'b1;
        // A release arriving in the swap cycle is consumed by this swap.
        if (rd_free_q || rd_release_i) begin
          pp_d      = ~pp_q;
          rd_free_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      ena_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      pp_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_free_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      ena_q     <= ena_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      pp_q      <= pp_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_free_q <= rd_free_d;
    end
  end

  assign wb_ready_o   = ready_q;
  assign ena          = ena_q;
  assign wea          = ena_q;
  assign addra        = addra_q;
  assign dina         = dina_q;
  assign ping_pong    = pp_q;
  assign layer_done_o = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_diff_fm_wb_ctrl.sv
// Directed bench for diff_fm_wb_ctrl: fill/swap, requantisation, reader blocking,
// valid gaps, configuration errors and asynchronous reset mid-layer.
module tb_diff_fm_wb_ctrl;
  localparam int ACC_W = 16, BL = 8, DEPTH = 16, AW = 4;

  logic          clk = 0, rst_n = 0;
  logic          layer_start_i = 0;
  logic [AW:0]   layer_len_i = '0;
  logic [3:0]    shift_i = '0;
  logic [ACC_W-1:0] wb_data_i = '0;
  logic          wb_valid_i = 0, rd_release_i = 0;
  logic          wb_ready_o, wea, ena, ping_pong, layer_done_o, err_o;
  logic [AW-1:0] addra;
  logic [BL-1:0] dina;

  int n_cmp = 0, n_bad = 0;

  diff_fm_wb_ctrl #(.ACC_W(ACC_W), .BIT_LENGTH(BL), .CONF_FM_BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .layer_start_i(layer_start_i), .layer_len_i(layer_len_i),
    .shift_i(shift_i), .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .rd_release_i(rd_release_i), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .ping_pong(ping_pong), .layer_done_o(layer_done_o), .err_o(err_o));

  always #5 clk = ~clk;

  // Advance one clock edge; outputs are observed 1ns after it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_layer(input int len, input int sh);
    layer_start_i = 1; layer_len_i = (AW+1)'(len); shift_i = 4'(sh);
    step();
    layer_start_i = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #12; rst_n = 1; step();
    n_cmp++; if ({wb_ready_o, ena, wea, ping_pong, layer_done_o, err_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 000000", {wb_ready_o, ena, wea, ping_pong, layer_done_o, err_o}); end
    n_cmp++; if ({addra, dina} !== 12'h0) begin
      n_bad++; $display("FAIL reset_addr_data got %h want 000", {addra, dina}); end
  endtask

  task automatic test_basic();
    logic [ACC_W-1:0] din [4];
    logic [BL-1:0]    exp [4];
    din = '{16'd5, 16'hFFFD, 16'd200, 16'd127};
    exp = '{8'd5, 8'd0, 8'd127, 8'd127};
    start_layer(4, 0);
    n_cmp++; if (wb_ready_o !== 1'b1) begin n_bad++; $display("FAIL basic_ready_rise got %b want 1", wb_ready_o); end
    wb_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      wb_data_i = din[i];
      step();
      n_cmp++; if ({ena, wea, addra, dina} !== {1'b1, 1'b1, AW'(i), exp[i]}) begin
        n_bad++; $display("FAIL basic_write%0d got ena=%b wea=%b addr=%0d dina=%0d want 1 1 %0d %0d", i, ena, wea, addra, dina, i, exp[i]); end
    end
    wb_valid_i = 0;
    n_cmp++; if ({wb_ready_o, layer_done_o, ping_pong} !== 3'b000) begin
      n_bad++; $display("FAIL basic_after_last got rdy/done/pp=%b want 000", {wb_ready_o, layer_done_o, ping_pong}); end
    step();
    n_cmp++; if ({layer_done_o, ping_pong, ena} !== 3'b110) begin
      n_bad++; $display("FAIL basic_swap got done/pp/ena=%b want 110", {layer_done_o, ping_pong, ena}); end
    step();
    n_cmp++; if ({layer_done_o, ping_pong} !== 2'b01) begin
      n_bad++; $display("FAIL basic_done_pulse got done/pp=%b want 01", {layer_done_o, ping_pong}); end
  endtask

  task automatic test_blocked();
    int early = 0;
    start_layer(2, 0);
    wb_valid_i = 1;
    wb_data_i = 16'd1; step();
    wb_data_i = 16'd2; step();
    n_cmp++; if ({ena, addra, dina} !== {1'b1, 4'd1, 8'd2}) begin
      n_bad++; $display("FAIL blocked_last_write got ena=%b addr=%0d dina=%0d want 1 1 2", ena, addra, dina); end
    wb_valid_i = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (layer_done_o !== 1'b0 || ping_pong !== 1'b1 || wb_ready_o !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL blocked_wait got %0d bad cycles want 0", early); end
    rd_release_i = 1; step(); rd_release_i = 0;
    n_cmp++; if ({layer_done_o, ping_pong} !== 2'b10) begin
      n_bad++; $display("FAIL blocked_swap got done/pp=%b want 10", {layer_done_o, ping_pong}); end
    step();
    n_cmp++; if (layer_done_o !== 1'b0) begin n_bad++; $display("FAIL blocked_done_pulse got %b want 0", layer_done_o); end
  endtask

  task automatic test_shift();
    logic [ACC_W-1:0] din [3];
    logic [BL-1:0]    exp [3];
    din = '{16'h0FF0, 16'h07F0, 16'h0150};
    exp = '{8'd127, 8'd127, 8'd21};
    start_layer(3, 4);
    wb_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      wb_data_i = din[i];
      rd_release_i = (i == 0);
      step();
      n_cmp++; if ({ena, addra, dina} !== {1'b1, AW'(i), exp[i]}) begin
        n_bad++; $display("FAIL shift_write%0d got ena=%b addr=%0d dina=%0d want 1 %0d %0d", i, ena, addra, dina, i, exp[i]); end
    end
    rd_release_i = 0; wb_valid_i = 0;
    step();
    n_cmp++; if ({layer_done_o, ping_pong} !== 2'b11) begin
      n_bad++; $display("FAIL shift_swap got done/pp=%b want 11", {layer_done_o, ping_pong}); end
  endtask

  task automatic test_gaps();
    logic       vpat [6];
    logic [7:0] dpat [6];
    int wr_idx = 0;
    logic prev_v = 0;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    dpat = '{8'd10, 8'd99, 8'd99, 8'd20, 8'd99, 8'd30};
    rd_release_i = 1; step(); rd_release_i = 0;
    start_layer(3, 1);
    for (int i = 0; i < 6; i++) begin
      wb_valid_i = vpat[i]; wb_data_i = {8'h0, dpat[i]};
      step();
      prev_v = vpat[i];
      n_cmp++; if (ena !== prev_v || (prev_v && (addra !== AW'(wr_idx) || dina !== BL'((wr_idx + 1) * 5)))) begin
        n_bad++; $display("FAIL gaps_cycle%0d got ena=%b addr=%0d dina=%0d want ena=%b addr=%0d dina=%0d", i, ena, addra, dina, prev_v, wr_idx, (wr_idx + 1) * 5); end
      if (prev_v) wr_idx++;
    end
    wb_valid_i = 0;
    step();
    n_cmp++; if ({layer_done_o, ping_pong, ena} !== 3'b100) begin
      n_bad++; $display("FAIL gaps_swap got done/pp/ena=%b want 100", {layer_done_o, ping_pong, ena}); end
  endtask

  task automatic test_errors();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_clean got %b want 0", err_o); end
    start_layer(0, 0);
    step();
    n_cmp++; if ({err_o, wb_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL err_len0 got err/rdy=%b want 10", {err_o, wb_ready_o}); end
    rst_n = 0; #2; rst_n = 1; step();
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_reset_clear got %b want 0", err_o); end
    start_layer(DEPTH + 1, 0);
    step();
    n_cmp++; if ({err_o, wb_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL err_len_big got err/rdy=%b want 10", {err_o, wb_ready_o}); end
    rst_n = 0; #2; rst_n = 1; step();
    start_layer(2, 0);
    wb_valid_i = 1; wb_data_i = 16'd7; step();
    layer_start_i = 1; layer_len_i = 5'd5; wb_data_i = 16'd8; step();
    layer_start_i = 0; wb_valid_i = 0;
    n_cmp++; if ({err_o, ena, addra, dina, wb_ready_o} !== {1'b1, 1'b1, 4'd1, 8'd8, 1'b0}) begin
      n_bad++; $display("FAIL err_in_fill got err=%b ena=%b addr=%0d dina=%0d rdy=%b want 1 1 1 8 0", err_o, ena, addra, dina, wb_ready_o); end
    step();
    n_cmp++; if ({layer_done_o, ping_pong, err_o} !== 3'b111) begin
      n_bad++; $display("FAIL err_fill_complete got done/pp/err=%b want 111", {layer_done_o, ping_pong, err_o}); end
  endtask

  task automatic test_reset_mid();
    step();
    start_layer(4, 0);
    wb_valid_i = 1; wb_data_i = 16'd9; step();
    wb_data_i = 16'd11; step();
    wb_valid_i = 0;
    n_cmp++; if ({ena, addra, dina, ping_pong} !== {1'b1, 4'd1, 8'd11, 1'b1}) begin
      n_bad++; $display("FAIL rstmid_pre got ena=%b addr=%0d dina=%0d pp=%b want 1 1 11 1", ena, addra, dina, ping_pong); end
    #2; rst_n = 0; #1;
    n_cmp++; if ({wb_ready_o, ena, wea, ping_pong, layer_done_o, err_o, addra, dina} !== 18'h0) begin
      n_bad++; $display("FAIL rstmid_outputs got %h want 0", {wb_ready_o, ena, wea, ping_pong, layer_done_o, err_o, addra, dina}); end
    step(); rst_n = 1; step();
    start_layer(1, 0);
    wb_valid_i = 1; wb_data_i = 16'd42; step(); wb_valid_i = 0;
    n_cmp++; if ({ena, addra, dina, wb_ready_o} !== {1'b1, 4'd0, 8'd42, 1'b0}) begin
      n_bad++; $display("FAIL rstmid_len1_write got ena=%b addr=%0d dina=%0d rdy=%b want 1 0 42 0", ena, addra, dina, wb_ready_o); end
    step();
    n_cmp++; if ({layer_done_o, ping_pong} !== 2'b11) begin
      n_bad++; $display("FAIL rstmid_swap got done/pp=%b want 11", {layer_done_o, ping_pong}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blocked();
    test_shift();
    test_gaps();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/diff_fm_wb_ctrl.md
# diff_fm_wb_ctrl

Write-back controller for one PE column: consumes the column's result stream from `PE_matrix`, applies ReLU and a saturating right-shift requantisation, and writes the results sequentially into port A of the column's feature-map `ping_pong_buffer`. When a layer's results are complete, it swaps banks once the reader has released the other bank. One instance sits between each `PE_matrix` write-back column output and its `fm_buf` inside `diff_core_top`.

## Interface
- `ACC_W`, 16: width of signed PE result word.
- `BIT_LENGTH`, 8: stored feature-map word width. Signed, non-negative after ReLU.
- `DEPTH`, `CONF_FM_BUF_DEPTH`: words per bank.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `clk` in 1: core clock. This is the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `layer_start_i` in 1: single-cycle pulse that starts a layer. Accepted only in IDLE.
- `layer_len_i` in ADDR_W+1: number of words in the layer. Sampled with `layer_start_i`.
- `shift_i` in 4: requantisation right-shift. Sampled with `layer_start_i`.
- `wb_data_i` in ACC_W: PE result word (signed).
- `wb_valid_i` in 1: result valid.
- `wb_ready_o` out 1: drives `PE_matrix` `fm_buf_ready`. Registered.
- `rd_release_i` in 1: pulse from the reader meaning the read bank is consumed.
- `addra` out ADDR_W, `dina` out BIT_LENGTH, `wea` out 1, `ena` out 1: buffer port A.
- `ping_pong` out 1: bank select to the buffer.
- `layer_done_o` out 1: one-cycle pulse on bank swap.
- `err_o` out 1: sticky configuration/protocol error.

## Operation
- **Reset values:** state IDLE; all outputs 0; `ping_pong`=0. Internal `rd_free`=1, because the read bank starts empty.
- **IDLE:**
  - `layer_start_i` with 1 ≤ `layer_len_i` ≤ DEPTH: capture len and shift, clear the address counter, go to FILL.
  - `layer_len_i`=0 or >DEPTH: set `err_o` and stay in IDLE.
- **FILL:**
  - `wb_ready_o`=1.
  - Each cycle with `wb_valid_i`&`wb_ready_o` is an accept. The word goes into a one-stage write register and the counter increments.
  - On the accept where count = len−1, go to WAIT_SWAP.
- **WAIT_SWAP:**
  - `wb_ready_o`=0.
  - When `rd_free` is set, or `rd_release_i`=1 in this same cycle: toggle `ping_pong`, clear `rd_free`, pulse `layer_done_o`, and go to IDLE.
- **`rd_free` flag:** set by `rd_release_i` in any state. A release while already set has no further effect. A release in the swap cycle is consumed by that swap, so `rd_free` ends 0.
- **`layer_start_i` outside IDLE:** ignored and sets `err_o`.
- **Requantisation:**
  - If `wb_data_i` is negative, the result is 0.
  - Otherwise v = `wb_data_i` >> shift (logical on the non-negative value); the result is min(v, 2^(BIT_LENGTH−1)−1).
  - There is no rounding.
- **`err_o`:** cleared only by reset.

## Timing
- **Write latency:** an accept in cycle t produces `ena`=`wea`=1 in t+1, with `addra` = the accept index (0..len−1) and `dina` = the requantised word. Otherwise `ena`=`wea`=0, and `addra`/`dina` hold their last value.
- **Ready timing:** `wb_ready_o` rises the cycle after `layer_start_i` is accepted. It falls the cycle after the last accept; that is the cycle the last write is issued.
- **Earliest swap:** if the last accept is in cycle t, the earliest swap is t+1 (WAIT_SWAP with `rd_free`=1). The last write also completes in t+1, and `ping_pong` changes at t+2. This guarantees the final write lands in the old bank.
- **Back-to-back layers:** `layer_start_i` is accepted in the cycle after `layer_done_o`.
- **Throughput:** one word per cycle in FILL.
- **Addressing:** no address wrap. The counter never exceeds len−1.
- **Asynchronous reset mid-layer:** forces IDLE immediately, sets `ping_pong`=0 and `rd_free`=1, and drops any pending write.

## Test plan
- **Basic fill and swap:** reset, start with len=4, shift=0, stream 5, −3, 200, 127 with valid held high. Required:
  - writes at addr 0..3 with `dina` = 5, 0, 127, 127;
  - `wb_ready_o` falls after the 4th accept;
  - `layer_done_o` 2 cycles after the last accept, `ping_pong`=1.
- **Shift and saturation:** shift=4, inputs 0x0FF0 and 0x07F0. Required: `dina` = 127 (0xFF saturated) and 127 (0x7F).
- **Swap blocked by reader:** after the first layer swaps (`rd_free`=0), run a second layer with len=2. Required:
  - the FSM waits in WAIT_SWAP with `layer_done_o` low;
  - when `rd_release_i` is pulsed 10 cycles later, the swap happens that cycle and `ping_pong` returns to 0.
- **Valid gaps:** len=3 with valid toggling 1,0,0,1,0,1. Required: exactly 3 writes, at addr 0, 1, 2, each one cycle after its accept.
- **Errors:** `layer_start_i` with len=0 in IDLE, and with len=DEPTH+1 in IDLE. Required: `err_o`=1 and the state stays IDLE. Then a `layer_start_i` during FILL: required `err_o`=1, the len and counter unchanged, and the layer completing normally.
- **Reset mid-FILL:** assert `rst_n`=0 after 2 accepts. Required: all outputs 0 immediately. Then a new len=1 layer completes and swaps immediately, because `rd_free`=1 after reset.
